// File: rtl/router_output_ctrl.sv
// router_output_ctrl
// Output stage for one direction of the mesh router. It takes packets from the
// five input controllers with round-robin arbitration, queues them in a small
// FIFO, and drives one outgoing link. Packets pass through unmodified.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : per-input request (0=N, 1=S, 2=E, 3=W, 4=PE)
//   in_data    : packets, slice i = [i*WIDTH_packet +: WIDTH_packet]
//   in_ready   : one-hot-or-zero grant to the requesting inputs
//   out_valid  : FIFO head valid
//   out_data   : FIFO head packet
//   out_ready  : downstream accepts the head this cycle
//   pkt_count  : packets delivered since reset (wraps)
module router_output_ctrl #(
    parameter int WIDTH_packet = 57,
    parameter int NUM_IN       = 5,
    parameter int DEPTH        = 2,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
    output logic [NUM_IN-1:0]              in_ready,
    output logic                           out_valid,
    output logic [WIDTH_packet-1:0]        out_data,
    input  logic                           out_ready,
    output logic [CNT_W-1:0]               pkt_count
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = $clog2(DEPTH) + 1;
    localparam int RR_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [WIDTH_packet-1:0] slice [NUM_IN];
    logic [WIDTH_packet-1:0] entry [DEPTH];

    logic [CNT_FW-1:0] count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [RR_W-1:0]   rr_ptr_reg;
    logic [RR_W-1:0]   rr_ptr_next;
    logic [CNT_W-1:0]  pkt_count_reg;

    logic [NUM_IN-1:0] grant;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W:0]     cand;
    logic              found;
    logic              can_push;
    logic              push;
    logic              pop;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
            assign slice[gi] = in_data[gi*WIDTH_packet +: WIDTH_packet];
        end
    endgenerate

    // Round-robin search: walk the inputs starting at rr_ptr, wrapping
    // modulo NUM_IN, and grant the first requester found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, rr_ptr_reg} + (RR_W+1)'(k);
            if (cand >= (RR_W+1)'(NUM_IN)) begin
                cand = cand - (RR_W+1)'(NUM_IN);
            end
            if (!found && in_valid[cand[RR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[RR_W-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // No grant while full (no full-and-pop pass-through) or while held in
    // reset, so an in-flight handshake is never accepted during reset.
    assign can_push = rst_n && (count_reg != CNT_FW'(DEPTH));
    assign in_ready = can_push ? grant : '0;
    assign push     = can_push && found;

    assign out_valid = (count_reg != '0);
    assign out_data  = entry[rd_ptr_reg];
    assign pop       = out_valid && out_ready;
    assign pkt_count = pkt_count_reg;

    // The just-served input drops to lowest priority.
    assign rr_ptr_next = (grant_idx == RR_W'(NUM_IN-1)) ? '0 : grant_idx + RR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rr_ptr_reg    <= '0;
            pkt_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                rr_ptr_reg <= rr_ptr_next;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
                pkt_count_reg <= pkt_count_reg + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_FW'(1);
                2'b01:   count_reg <= count_reg - CNT_FW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; cleared on reset so out_data reads zero afterwards.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [WIDTH_packet-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= slice[grant_idx];
                end
            end
            assign entry[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: doc/router_output_ctrl.md
# router_output_ctrl

Per-direction output stage of the mesh router. It collects packets steered toward one output direction by the five input controllers (north, south, east, west, PE) and arbitrates among them with a round-robin policy. Accepted packets go into a small FIFO, which drives a single outgoing link toward the neighbouring router or local PE. Packets pass through unmodified: hop-count decrement and direction decode are done upstream.

## Interface
- WIDTH_packet, 57: packet width in bits; carried opaquely.
- NUM_IN, 5: number of requesting input controllers; index 0=north, 1=south, 2=east, 3=west, 4=PE.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 16: width of the delivered-packet counter.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_IN  per-input request; bit i means in_data slice i holds a packet.
- in_data  input  NUM_IN*WIDTH_packet  packets; slice i = [i*WIDTH_packet +: WIDTH_packet].
- in_ready  output  NUM_IN  one-hot-or-zero grant; bit i high means slice i is accepted this cycle.
- out_valid  output  1  FIFO head is valid.
- out_data  output  WIDTH_packet  FIFO head packet.
- out_ready  input  1  downstream accepts out_data this cycle.
- pkt_count  output  CNT_W  number of packets delivered on the output since reset.

## Operation
- Handshake on both sides: a transfer occurs on a rising edge where valid and ready are both high.
- Senders must hold in_valid and data stable until the transfer. Downstream sees out_valid/out_data stable until out_ready.
- Arbitration is combinational within the cycle.
  - When the FIFO occupancy count < DEPTH, search in_valid starting at index rr_ptr, ascending and wrapping modulo NUM_IN.
  - The first set bit g gets in_ready[g]=1. All other in_ready bits are 0.
  - When count == DEPTH, in_ready is all zero. There is no full-and-pop pass-through.
  - in_ready depends on in_valid. Upstream must not make in_valid depend on in_ready.
- On a push, write in_data slice g at the write pointer and set rr_ptr = (g+1) mod NUM_IN.
  - With no push, rr_ptr holds.
  - The just-served input therefore has lowest priority next time.
- Pop: out_valid = (count != 0) and out_data = entry at the read pointer. A pop advances the read pointer.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH, with width clog2(DEPTH)+1.
- pkt_count increments by 1 on every pop and wraps from 2^CNT_W−1 to 0.
- No packet is ever dropped, duplicated, or reordered relative to its acceptance order.

## Timing
- Reset (rst_n low, asynchronous assert):
  - count=0, both FIFO pointers=0, rr_ptr=0, pkt_count=0.
  - out_valid=0, out_data=0 (storage cleared).
  - in_ready forced to 0 while rst_n is low.
- Reset mid-operation discards all buffered packets immediately. A packet whose handshake is in progress is not accepted.
- Deassertion is taken synchronously to clk by the surrounding reset synchronizer. The first transfer can occur on the first rising edge with rst_n high.
- Latency: a packet accepted at edge N is visible on out_data with out_valid=1 after edge N (cycle N+1) when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one packet per cycle sustained when out_ready stays high.
- Fairness: with all NUM_IN inputs continuously valid and out_ready=1, each input is served exactly once every NUM_IN accepted packets.
- Backpressure: with out_ready=0, exactly DEPTH packets are accepted, then all in_ready stay 0 until the first pop edge. One push is possible on the cycle after that pop.

## Test plan
- Reset check: hold rst_n=0 with in_valid=5'b11111 -> in_ready=0, out_valid=0, pkt_count=0. Assert rst_n low mid-stream with count=2 -> out_valid drops to 0 asynchronously.
- Single packet: in_valid[4]=1, in_data slice 4 = 57'h1_2345_6789_ABCD, out_ready=1 -> in_ready=5'b10000 at edge 1. out_valid=1 and out_data=57'h1_2345_6789_ABCD in cycle 2. pkt_count=1 after edge 2. rr_ptr=0.
- Round-robin: all five inputs valid with distinct tags 0..4, out_ready=1, 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4 and output order matches.
- Skip and wrap: rr_ptr=3, in_valid=5'b00101 -> input 0 granted first, then input 2, then input 0.
- Full FIFO: out_ready=0, inputs 1 and 3 valid -> two pushes (1 then 3), then in_ready=0. Raise out_ready -> output order 1,3, and input 1 is accepted on the next grant.
- Simultaneous push/pop at count=1 for 20 cycles -> count stays 1 and the output sequence equals the input sequence. pkt_count wrap check with CNT_W=4 after 16 pops -> pkt_count=0.
